// File: rtl/ppu_bg_fetch.sv
// Background tile fetch sequencer: runs the 8-dot NT/AT/pattern fetch cadence on the PPU bus
// and feeds the 16-bit background shifters that produce one pixel per dot.
module ppu_bg_fetch #(
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        render_en,
  input  logic [8:0]  cycle,
  input  logic [14:0] v,
  input  logic [2:0]  fine_x,
  input  logic        bg_sel,
  output logic [13:0] addr,
  output logic        rw,
  input  logic [7:0]  data_i,
  output logic [3:0]  bg_pix,
  output logic        hinc
);

  if (FETCH_LAT != 1) begin : g_bad_lat
    $error("ppu_bg_fetch: only FETCH_LAT = 1 is supported");
  end

  logic [2:0]  phase;
  logic        in_fetch;
  logic        in_dummy;
  logic        in_shift;
  logic        reload;

  logic [13:0] addr_q, addr_d;
  logic [7:0]  nt_q, nt_d;
  logic [1:0]  at_q, at_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] pat_lo_q, pat_lo_d;
  logic [15:0] pat_hi_q, pat_hi_d;
  logic [15:0] att_lo_q, att_lo_d;
  logic [15:0] att_hi_q, att_hi_d;

  logic [13:0] nt_addr;
  logic [13:0] at_addr;
  logic [13:0] pl_addr;
  logic [13:0] ph_addr;
  logic [13:0] addr_drv;
  logic        addr_vld;
  logic [2:0]  at_shamt;
  logic [7:0]  at_shifted;
  logic [3:0]  sel;

  // (cycle - 1) mod 8; dot 0 lands on phase 7 but is outside every window.
  assign phase    = cycle[2:0] - 3'd1;
  assign in_fetch = ((cycle >= 9'd1) && (cycle <= 9'd256)) ||
                    ((cycle >= 9'd321) && (cycle <= 9'd336));
  assign in_dummy = (cycle == 9'd337) || (cycle == 9'd339);
  assign in_shift = ((cycle >= 9'd2) && (cycle <= 9'd257)) ||
                    ((cycle >= 9'd322) && (cycle <= 9'd337));
  assign reload   = in_shift && (phase == 3'd0);

  assign nt_addr = {2'b10, v[11:0]};
  assign at_addr = 14'h23C0 | {2'b00, v[11:10], 4'b0000, v[9:7], v[4:2]};
  assign pl_addr = {1'b0, bg_sel, nt_q, 1'b0, v[14:12]};
  assign ph_addr = pl_addr + 14'd8;

  // Attribute quadrant select from coarse Y bit 1 and coarse X bit 1.
  assign at_shamt   = {v[6], v[1], 1'b0};
  assign at_shifted = data_i >> at_shamt;

  always_comb begin
    addr_drv = 14'h0000;
    addr_vld = 1'b0;
    if (render_en) begin
      if (in_fetch) begin
        unique case (phase)
          3'd0: begin addr_drv = nt_addr; addr_vld = 1'b1; end
          3'd2: begin addr_drv = at_addr; addr_vld = 1'b1; end
          3'd4: begin addr_drv = pl_addr; addr_vld = 1'b1; end
          3'd6: begin addr_drv = ph_addr; addr_vld = 1'b1; end
          default: ;
        endcase
      end else if (in_dummy) begin
        addr_drv = nt_addr;
        addr_vld = 1'b1;
      end
    end
  end

  always_comb begin
    addr_d   = addr_vld ? addr_drv : addr_q;
    nt_d     = nt_q;
    at_d     = at_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    pat_lo_d = pat_lo_q;
    pat_hi_d = pat_hi_q;
    att_lo_d = att_lo_q;
    att_hi_d = att_hi_q;

    if (render_en && in_fetch) begin
      unique case (phase)
        3'd1: nt_d = data_i;
        3'd3: at_d = at_shifted[1:0];
        3'd5: lo_d = data_i;
        3'd7: hi_d = data_i;
        default: ;
      endcase
    end

    if (render_en && in_shift) begin
      pat_lo_d = {pat_lo_q[14:0], 1'b0};
      pat_hi_d = {pat_hi_q[14:0], 1'b0};
      att_lo_d = {att_lo_q[14:0], 1'b0};
      att_hi_d = {att_hi_q[14:0], 1'b0};
      // Shift first, then the new tile lands in the low byte.
      if (reload) begin
        pat_lo_d[7:0] = lo_q;
        pat_hi_d[7:0] = hi_q;
        att_lo_d[7:0] = {8{at_q[0]}};
        att_hi_d[7:0] = {8{at_q[1]}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      nt_q     <= '0;
      at_q     <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      pat_lo_q <= '0;
      pat_hi_q <= '0;
      att_lo_q <= '0;
      att_hi_q <= '0;
    end else begin
      addr_q   <= addr_d;
      nt_q     <= nt_d;
      at_q     <= at_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      pat_lo_q <= pat_lo_d;
      pat_hi_q <= pat_hi_d;
      att_lo_q <= att_lo_d;
      att_hi_q <= att_hi_d;
    end
  end

  assign sel = 4'd15 - {1'b0, fine_x};

  // Gate with rst so the address dot's combinational path cannot leak during reset.
  assign addr   = rst ? 14'h0000 : addr_d;
  assign rw     = 1'b1;
  assign hinc   = !rst && render_en && in_fetch && (phase == 3'd7);
  assign bg_pix = (!rst && render_en) ?
                  {att_hi_q[sel], att_lo_q[sel], pat_hi_q[sel], pat_lo_q[sel]} : 4'b0000;

endmodule
